// File: rtl/scr1_pipe_ialu_issue.sv
`default_nettype none
// ============================================================================
// Module   : scr1_pipe_ialu_issue
// Purpose  : Single-outstanding issue stage in front of scr1_pipe_ialu with
//            MUL/DIV timeout guard and completed-operation counter.
// Revision : 1.0 - initial release
// ============================================================================

package scr1_ialu_issue_pkg;

    typedef enum logic [4:0] {
        SCR1_IALU_CMD_NONE    = 5'd0,
        SCR1_IALU_CMD_AND     = 5'd1,
        SCR1_IALU_CMD_OR      = 5'd2,
        SCR1_IALU_CMD_XOR     = 5'd3,
        SCR1_IALU_CMD_ADD     = 5'd4,
        SCR1_IALU_CMD_SUB     = 5'd5,
        SCR1_IALU_CMD_SUB_LT  = 5'd6,
        SCR1_IALU_CMD_SUB_LTU = 5'd7,
        SCR1_IALU_CMD_SUB_EQ  = 5'd8,
        SCR1_IALU_CMD_SUB_NE  = 5'd9,
        SCR1_IALU_CMD_SUB_GE  = 5'd10,
        SCR1_IALU_CMD_SUB_GEU = 5'd11,
        SCR1_IALU_CMD_SLL     = 5'd12,
        SCR1_IALU_CMD_SRL     = 5'd13,
        SCR1_IALU_CMD_SRA     = 5'd14,
        SCR1_IALU_CMD_MUL     = 5'd15,
        SCR1_IALU_CMD_MULHU   = 5'd16,
        SCR1_IALU_CMD_MULHSU  = 5'd17,
        SCR1_IALU_CMD_MULH    = 5'd18,
        SCR1_IALU_CMD_DIV     = 5'd19,
        SCR1_IALU_CMD_DIVU    = 5'd20,
        SCR1_IALU_CMD_REM     = 5'd21,
        SCR1_IALU_CMD_REMU    = 5'd22
    } type_scr1_ialu_cmd_sel_e;

endpackage

module scr1_pipe_ialu_issue
    import scr1_ialu_issue_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RVM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vd_i,
    output logic                    req_rdy_o,
    input  type_scr1_ialu_cmd_sel_e req_cmd_i,
    input  logic [XLEN-1:0]         req_op1_i,
    input  logic [XLEN-1:0]         req_op2_i,
    output type_scr1_ialu_cmd_sel_e ialu_cmd_o,
    output logic [XLEN-1:0]         ialu_main_op1_o,
    output logic [XLEN-1:0]         ialu_main_op2_o,
    output logic                    ialu_rvm_cmd_vd_o,
    input  logic                    ialu_rvm_res_rdy_i,
    input  logic [XLEN-1:0]         ialu_main_res_i,
    input  logic                    ialu_cmp_res_i,
    output logic                    rsp_vd_o,
    input  logic                    rsp_rdy_i,
    output logic [XLEN-1:0]         rsp_res_o,
    output logic                    rsp_cmp_o,
    output logic                    rsp_err_o,
    output logic [CNT_W-1:0]        op_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_RVM = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // Counter value at which the last permitted WAIT_RVM cycle is running;
    // EXEC plus WAIT_RVM then spans exactly RVM_TIMEOUT cycles of cmd_vd.
    localparam logic [7:0] c_tmo_last = 8'(RVM_TIMEOUT - 2);

    state_e                  r_state;
    type_scr1_ialu_cmd_sel_e r_cmd;
    logic [XLEN-1:0]         r_op1;
    logic [XLEN-1:0]         r_op2;
    logic                    r_req_rdy;
    logic                    r_rvm_vd;
    logic                    r_rsp_vd;
    logic [XLEN-1:0]         r_rsp_res;
    logic                    r_rsp_cmp;
    logic                    r_rsp_err;
    logic [CNT_W-1:0]        r_op_cnt;
    logic [7:0]              r_tmo_cnt;

    logic                    w_req_rvm;
    logic                    w_capture;
    logic                    w_timeout;

    assign w_req_rvm = req_cmd_i inside {SCR1_IALU_CMD_MUL,  SCR1_IALU_CMD_MULH,
                                         SCR1_IALU_CMD_MULHSU, SCR1_IALU_CMD_MULHU,
                                         SCR1_IALU_CMD_DIV,  SCR1_IALU_CMD_DIVU,
                                         SCR1_IALU_CMD_REM,  SCR1_IALU_CMD_REMU};

    // A ready result always beats a simultaneous timeout.
    assign w_capture = ((r_state == ST_EXEC) && (!r_rvm_vd || ialu_rvm_res_rdy_i))
                     || ((r_state == ST_WAIT_RVM) && ialu_rvm_res_rdy_i);
    assign w_timeout = (r_state == ST_WAIT_RVM) && !ialu_rvm_res_rdy_i
                     && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cmd     <= SCR1_IALU_CMD_NONE;
            r_op1     <= '0;
            r_op2     <= '0;
            r_req_rdy <= 1'b1;
            r_rvm_vd  <= 1'b0;
            r_rsp_vd  <= 1'b0;
            r_rsp_res <= '0;
            r_rsp_cmp <= 1'b0;
            r_rsp_err <= 1'b0;
            r_op_cnt  <= '0;
            r_tmo_cnt <= '0;
        end else if (w_capture || w_timeout) begin
            r_rsp_res <= w_capture ? ialu_main_res_i : '1;
            r_rsp_cmp <= w_capture & ialu_cmp_res_i;
            r_rsp_err <= w_timeout;
            r_rsp_vd  <= 1'b1;
            r_rvm_vd  <= 1'b0;
            r_cmd     <= SCR1_IALU_CMD_NONE;
            r_op1     <= '0;
            r_op2     <= '0;
            r_state   <= ST_RESP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_vd_i) begin
                        r_cmd     <= req_cmd_i;
                        r_op1     <= req_op1_i;
                        r_op2     <= req_op2_i;
                        r_rvm_vd  <= w_req_rvm;
                        r_req_rdy <= 1'b0;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_RVM;
                end
                ST_WAIT_RVM: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                end
                ST_RESP: begin
                    if (rsp_rdy_i) begin
                        r_rsp_vd  <= 1'b0;
                        r_op_cnt  <= r_op_cnt + 1'b1;
                        r_req_rdy <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_rdy_o         = r_req_rdy;
    assign ialu_cmd_o        = r_cmd;
    assign ialu_main_op1_o   = r_op1;
    assign ialu_main_op2_o   = r_op2;
    assign ialu_rvm_cmd_vd_o = r_rvm_vd;
    assign rsp_vd_o          = r_rsp_vd;
    assign rsp_res_o         = r_rsp_res;
    assign rsp_cmp_o         = r_rsp_cmp;
    assign rsp_err_o         = r_rsp_err;
    assign op_cnt_o          = r_op_cnt;

endmodule

`default_nettype wire

// File: tb/tb_scr1_pipe_ialu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_pipe_ialu_issue
// Purpose  : Randomized scoreboard bench for scr1_pipe_ialu_issue with an
//            IALU / MUL-DIV responder model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_scr1_pipe_ialu_issue;
    import scr1_ialu_issue_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 8;
    localparam int CW   = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req_vd_i = 1'b0;
    logic                    req_rdy_o;
    type_scr1_ialu_cmd_sel_e req_cmd_i = SCR1_IALU_CMD_NONE;
    logic [XLEN-1:0]         req_op1_i = '0;
    logic [XLEN-1:0]         req_op2_i = '0;
    type_scr1_ialu_cmd_sel_e ialu_cmd_o;
    logic [XLEN-1:0]         ialu_main_op1_o;
    logic [XLEN-1:0]         ialu_main_op2_o;
    logic                    ialu_rvm_cmd_vd_o;
    logic                    ialu_rvm_res_rdy_i = 1'b0;
    logic [XLEN-1:0]         ialu_main_res_i;
    logic                    ialu_cmp_res_i;
    logic                    rsp_vd_o;
    logic                    rsp_rdy_i = 1'b0;
    logic [XLEN-1:0]         rsp_res_o;
    logic                    rsp_cmp_o;
    logic                    rsp_err_o;
    logic [CW-1:0]           op_cnt_o;

    int checks = 0;
    int errors = 0;

    scr1_pipe_ialu_issue #(.XLEN(XLEN), .RVM_TIMEOUT(TMO), .CNT_W(CW)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .req_vd_i          (req_vd_i),
        .req_rdy_o         (req_rdy_o),
        .req_cmd_i         (req_cmd_i),
        .req_op1_i         (req_op1_i),
        .req_op2_i         (req_op2_i),
        .ialu_cmd_o        (ialu_cmd_o),
        .ialu_main_op1_o   (ialu_main_op1_o),
        .ialu_main_op2_o   (ialu_main_op2_o),
        .ialu_rvm_cmd_vd_o (ialu_rvm_cmd_vd_o),
        .ialu_rvm_res_rdy_i(ialu_rvm_res_rdy_i),
        .ialu_main_res_i   (ialu_main_res_i),
        .ialu_cmp_res_i    (ialu_cmp_res_i),
        .rsp_vd_o          (rsp_vd_o),
        .rsp_rdy_i         (rsp_rdy_i),
        .rsp_res_o         (rsp_res_o),
        .rsp_cmp_o         (rsp_cmp_o),
        .rsp_err_o         (rsp_err_o),
        .op_cnt_o          (op_cnt_o)
    );

    always #5 clk = ~clk;

    // RISC-V arithmetic semantics of the IALU, returned as {cmp, result}.
    function automatic logic [32:0] alu_f(type_scr1_ialu_cmd_sel_e c, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        k;
        logic [63:0] p;
        r = '0;
        k = 1'b0;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            SCR1_IALU_CMD_AND:     r = a & b;
            SCR1_IALU_CMD_OR:      r = a | b;
            SCR1_IALU_CMD_XOR:     r = a ^ b;
            SCR1_IALU_CMD_ADD:     r = a + b;
            SCR1_IALU_CMD_SUB:     r = a - b;
            SCR1_IALU_CMD_SUB_LT:  begin r = a - b; k = $signed(a) < $signed(b); end
            SCR1_IALU_CMD_SUB_LTU: begin r = a - b; k = a < b; end
            SCR1_IALU_CMD_SUB_EQ:  begin r = a - b; k = a == b; end
            SCR1_IALU_CMD_MUL:     r = p[31:0];
            SCR1_IALU_CMD_MULHU:   r = p[63:32];
            SCR1_IALU_CMD_DIV: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            SCR1_IALU_CMD_DIVU:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            SCR1_IALU_CMD_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
            SCR1_IALU_CMD_REMU:    r = (b == 0) ? a : a % b;
            default:               r = '0;
        endcase
        return {k, r};
    endfunction

    function automatic bit is_rvm(type_scr1_ialu_cmd_sel_e c);
        return c inside {SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_DIV,
                         SCR1_IALU_CMD_DIVU, SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU};
    endfunction

    type_scr1_ialu_cmd_sel_e cmd_tab [14] = '{
        SCR1_IALU_CMD_AND, SCR1_IALU_CMD_OR, SCR1_IALU_CMD_XOR, SCR1_IALU_CMD_ADD,
        SCR1_IALU_CMD_SUB, SCR1_IALU_CMD_SUB_LT, SCR1_IALU_CMD_SUB_LTU, SCR1_IALU_CMD_SUB_EQ,
        SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_DIV, SCR1_IALU_CMD_DIVU,
        SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU};

    function automatic type_scr1_ialu_cmd_sel_e rand_cmd();
        return cmd_tab[$urandom_range(0, 13)];
    endfunction

    // IALU stand-in: combinational from whatever the issue stage drives.
    assign {ialu_cmp_res_i, ialu_main_res_i} = alu_f(ialu_cmd_o, ialu_main_op1_o, ialu_main_op2_o);

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic        err;
        int          lat;
        int          cvd;
        int          hold;
    } exp_t;

    exp_t exp_q[$];
    int   rvm_delay = -1;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    bit   in_rsp    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edge index of each request acceptance; latency counts the accepting cycle as 0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && req_vd_i && req_rdy_o) acc_cyc <= cyc + 1;
    end

    // MUL/DIV unit model: result ready in cmd_vd cycle rvm_delay+1; never if negative.
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (ialu_rvm_cmd_vd_o && !rst) begin
                rcnt++;
                ialu_rvm_res_rdy_i = (rvm_delay >= 0) && (rcnt == rvm_delay + 1);
            end else begin
                rcnt = 0;
                ialu_rvm_res_rdy_i = 1'b0;
            end
        end
    end

    // Monitor: pops on each new response and checks it while it is held.
    initial begin
        exp_t cur;
        int   cvd_cnt;
        int   hold_cnt;
        int   exp_cnt;
        cvd_cnt = 0; hold_cnt = 0; exp_cnt = 0;
        cur = '{res: '0, cmp: 1'b0, err: 1'b0, lat: 0, cvd: 0, hold: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp = 1'b0; cvd_cnt = 0; exp_cnt = 0; rsp_rdy_i = 1'b0;
            end else begin
                if (ialu_rvm_cmd_vd_o) cvd_cnt++;
                if (rsp_vd_o) begin
                    if (!in_rsp) begin
                        in_rsp = 1'b1;
                        hold_cnt = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_rsp", 1, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("latency", 64'(cyc - acc_cyc + 1), 64'(cur.lat));
                            chk("cmd_vd_cycles", 64'(cvd_cnt), 64'(cur.cvd));
                        end
                        cvd_cnt = 0;
                    end
                    chk("rsp_res", rsp_res_o, cur.res);
                    chk("rsp_cmp", rsp_cmp_o, cur.cmp);
                    chk("rsp_err", rsp_err_o, cur.err);
                    chk("req_rdy_in_resp", req_rdy_o, 0);
                    rsp_rdy_i = (hold_cnt >= cur.hold);
                    hold_cnt++;
                end else begin
                    if (in_rsp) begin
                        exp_cnt++;
                        chk("op_cnt", op_cnt_o, 64'(exp_cnt));
                        chk("req_rdy_after_rsp", req_rdy_o, 1);
                        in_rsp = 1'b0;
                    end
                    rsp_rdy_i = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic do_op(input type_scr1_ialu_cmd_sel_e c, input logic [31:0] a,
                         input logic [31:0] b, input int d, input int hold);
        exp_t        e;
        logic [32:0] r;
        int          n;
        n = 0;
        @(negedge clk);
        while (!req_rdy_o && n < 300) begin
            req_vd_i  = 1'($urandom_range(0, 1));
            req_cmd_i = rand_cmd();
            req_op1_i = $urandom;
            req_op2_i = $urandom;
            @(negedge clk);
            n++;
        end
        if (!req_rdy_o) begin
            chk("req_rdy_timeout", 0, 1);
            req_vd_i = 1'b0;
            return;
        end
        rvm_delay = d;
        req_vd_i  = 1'b1;
        req_cmd_i = c;
        req_op1_i = a;
        req_op2_i = b;
        r = alu_f(c, a, b);
        e = '{res: r[31:0], cmp: r[32], err: 1'b0, lat: 2, cvd: 0, hold: hold};
        if (is_rvm(c)) begin
            if (d >= 0 && d + 1 <= TMO) begin
                e.lat = d + 2;
                e.cvd = d + 1;
            end else begin
                e = '{res: '1, cmp: 1'b0, err: 1'b1, lat: TMO + 1, cvd: TMO, hold: hold};
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_vd_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_rsp || !req_rdy_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_req_rdy", req_rdy_o, 1);
        chk("rst_rsp_vd", rsp_vd_o, 0);
        chk("rst_cmd_vd", ialu_rvm_cmd_vd_o, 0);
        chk("rst_op_cnt", op_cnt_o, 0);
        chk("rst_rsp_res", rsp_res_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_ialu_cmd", ialu_cmd_o, SCR1_IALU_CMD_NONE);
        chk("rst_ialu_op1", ialu_main_op1_o, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(SCR1_IALU_CMD_ADD,    32'd8,  32'd6,  -1, 0);
        do_op(SCR1_IALU_CMD_ADD,    32'd9,  32'd1,  -1, 5);
        do_op(SCR1_IALU_CMD_SUB,    32'd10, 32'd15, -1, 1);
        do_op(SCR1_IALU_CMD_SUB_LT, 32'd10, 32'd15, -1, 0);
        do_op(SCR1_IALU_CMD_MUL,    32'd7,  32'd6,   3, 0);
        do_op(SCR1_IALU_CMD_DIV,    32'd100, 32'd7, -1, 2);
        do_op(SCR1_IALU_CMD_ADD,    32'd1,  32'd1,  -1, 0);
        do_op(SCR1_IALU_CMD_DIVU,   32'd99, 32'd0,   0, 0);
        do_op(SCR1_IALU_CMD_REMU,   32'd17, 32'd5,  TMO - 1, 1);
        do_op(SCR1_IALU_CMD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, TMO, 0);

        for (int i = 0; i < 40; i++) begin
            type_scr1_ialu_cmd_sel_e c;
            logic [31:0] a, b;
            int d;
            c = rand_cmd();
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TMO);
            do_op(c, a, b, d, $urandom_range(0, 3));
        end
        drain();

        // Asynchronous reset in the middle of a stalled divide.
        @(negedge clk);
        rvm_delay = -1;
        req_vd_i  = 1'b1;
        req_cmd_i = SCR1_IALU_CMD_DIV;
        req_op1_i = 32'd50;
        req_op2_i = 32'd5;
        @(posedge clk);
        @(negedge clk);
        req_vd_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_cmd_vd", ialu_rvm_cmd_vd_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmd_vd", ialu_rvm_cmd_vd_o, 0);
        chk("arst_rsp_vd", rsp_vd_o, 0);
        chk("arst_op_cnt", op_cnt_o, 0);
        chk("arst_ialu_cmd", ialu_cmd_o, SCR1_IALU_CMD_NONE);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_rdy", req_rdy_o, 1);
        do_op(SCR1_IALU_CMD_ADD, 32'd3, 32'd4, -1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
